// File: rtl/dvp_capture_crop_if.sv
// Camera-side DVP bus bundle.
//
// The camera (or a bench standing in for it) drives the bus through the
// master modport; the capture stage samples it through the slave modport.
//   Vsync  camera vsync, high during vertical blanking
//   Href   camera line valid
//   Data   camera data byte (DATA_W bits)
interface dvp_capture_crop_if #(
    parameter int DATA_W = 8
) ();
    logic              Vsync;
    logic              Href;
    logic [DATA_W-1:0] Data;

    modport master (output Vsync, output Href, output Data);
    modport slave  (input  Vsync, input  Href, input  Data);
endinterface

// File: rtl/dvp_capture_crop.sv
// DVP camera capture stage with crop window, start-up frame skip and frame
// decimation. Assembles BEATS-beat pixels from the camera byte bus (first
// beat in the MSBs) and emits one-cycle pixel strobes with window-relative
// coordinates. Runs entirely in the camera pixel clock domain.
//
// Ports
//   PCLK, Rst_n            pixel clock, asynchronous active-low reset
//   cam (slave)            Vsync / Href / Data from the camera
//   crop_x0, crop_y0       window origin (pixels / lines), latched per frame
//   crop_w, crop_h         window size, 0 captures nothing, latched per frame
//   decim                  keep one frame out of decim+1, sampled per frame
//   ImageState             high until SKIP_FRAMES frames have elapsed
//   DataValid, DataPixel   one-cycle pixel strobe and assembled pixel
//   Xaddr, Yaddr           coordinates relative to the window origin
//   FrameStart, FrameDone  first-pixel and end-of-captured-frame pulses
//   frame_pix_cnt          pixels emitted in the last captured frame
module dvp_capture_crop #(
    parameter int DATA_W      = 8,
    parameter int BEATS       = 2,
    parameter int ADDR_W      = 12,
    parameter int SKIP_FRAMES = 10
) (
    input  logic                    PCLK,
    input  logic                    Rst_n,
    dvp_capture_crop_if.slave       cam,
    input  logic [ADDR_W-1:0]       crop_x0,
    input  logic [ADDR_W-1:0]       crop_y0,
    input  logic [ADDR_W-1:0]       crop_w,
    input  logic [ADDR_W-1:0]       crop_h,
    input  logic [3:0]              decim,
    output logic                    ImageState,
    output logic                    DataValid,
    output logic [DATA_W*BEATS-1:0] DataPixel,
    output logic [ADDR_W-1:0]       Xaddr,
    output logic [ADDR_W-1:0]       Yaddr,
    output logic                    FrameStart,
    output logic                    FrameDone,
    output logic [23:0]             frame_pix_cnt
);

    localparam int               PIX_W     = DATA_W * BEATS;
    localparam int               BEAT_W    = 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [7:0]       SKIP_N    = 8'(SKIP_FRAMES);
    localparam logic             IS_RST    = (SKIP_FRAMES != 0);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // org <= pos < org+len, with the upper bound formed one bit wider so a
    // window reaching past 2^ADDR_W does not wrap around.
    function automatic logic in_span(input logic [ADDR_W-1:0] pos,
                                     input logic [ADDR_W-1:0] org,
                                     input logic [ADDR_W-1:0] len);
        logic [ADDR_W:0] lim;
        lim = {1'b0, org} + {1'b0, len};
        return (pos >= org) && ({1'b0, pos} < lim);
    endfunction

    logic              vsync_p0, href_p0, vsync_p1, href_p1;
    logic [DATA_W-1:0] data_p0;

    logic [BEAT_W-1:0] beat;
    logic [ADDR_W-1:0] raw_x, raw_y;
    logic [ADDR_W-1:0] cx0, cy0, cw, ch;
    logic [7:0]        skip_cnt;
    logic [3:0]        dcnt;
    logic              active;
    logic [23:0]       pix_cnt;

    logic              boundary, href_fall, pix_done, hit;
    logic [PIX_W-1:0]  pix_next;

    // ---- stage 1: register the camera pins ----
    always_ff @(posedge PCLK or negedge Rst_n) begin
        if (!Rst_n) begin
            vsync_p0 <= 1'b0;
            href_p0  <= 1'b0;
            vsync_p1 <= 1'b0;
            href_p1  <= 1'b0;
        end else begin
            vsync_p0 <= cam.Vsync;
            href_p0  <= cam.Href;
            vsync_p1 <= vsync_p0;
            href_p1  <= href_p0;
        end
    end

    always_ff @(posedge PCLK) begin
        data_p0 <= cam.Data;
    end

    assign boundary  = vsync_p0 & ~vsync_p1;
    assign href_fall = href_p1 & ~href_p0;
    // A frame boundary overrides any beat arriving in the same cycle.
    assign pix_done  = href_p0 && (beat == LAST_BEAT) && !boundary;
    assign hit       = pix_done && active &&
                       in_span(raw_x, cx0, cw) && in_span(raw_y, cy0, ch);

    // Earlier beats of the pixel sit in acc; the current beat is appended
    // at the LSB end, so after BEATS beats the first one is in the MSBs.
    generate
        if (BEATS > 1) begin : g_multi
            logic [PIX_W-DATA_W-1:0] acc;
            always_ff @(posedge PCLK) begin
                if (href_p0) acc <= pix_next[PIX_W-DATA_W-1:0];
            end
            assign pix_next = {acc, data_p0};
        end else begin : g_single
            assign pix_next = data_p0;
        end
    endgenerate

    // ---- stage 2: frame / line / pixel control and output registers ----
    always_ff @(posedge PCLK or negedge Rst_n) begin
        if (!Rst_n) begin
            beat          <= '0;
            raw_x         <= '0;
            raw_y         <= '0;
            cx0           <= '0;
            cy0           <= '0;
            cw            <= '0;
            ch            <= '0;
            skip_cnt      <= '0;
            dcnt          <= '0;
            active        <= 1'b0;
            pix_cnt       <= '0;
            ImageState    <= IS_RST;
            DataValid     <= 1'b0;
            DataPixel     <= '0;
            Xaddr         <= '0;
            Yaddr         <= '0;
            FrameStart    <= 1'b0;
            FrameDone     <= 1'b0;
            frame_pix_cnt <= '0;
        end else begin
            DataValid  <= 1'b0;
            FrameStart <= 1'b0;
            FrameDone  <= 1'b0;
            if (boundary) begin
                beat    <= '0;
                raw_x   <= '0;
                raw_y   <= '0;
                pix_cnt <= '0;
                cx0     <= crop_x0;
                cy0     <= crop_y0;
                cw      <= crop_w;
                ch      <= crop_h;
                if (active && (pix_cnt != 24'd0)) begin
                    FrameDone     <= 1'b1;
                    frame_pix_cnt <= pix_cnt;
                end
                if (skip_cnt < SKIP_N) skip_cnt <= skip_cnt + 8'd1;
                ImageState <= (({1'b0, skip_cnt} + 9'd1) < {1'b0, SKIP_N});
                // The frame being opened is judged by the skip state it
                // inherits, so the boundary that ends skipping still opens
                // a discarded frame. Decimation phase starts at the first
                // kept frame.
                if (ImageState) begin
                    active <= 1'b0;
                    dcnt   <= '0;
                end else begin
                    active <= (dcnt == 4'd0);
                    dcnt   <= (dcnt >= decim) ? 4'd0 : dcnt + 4'd1;
                end
            end else begin
                if (href_p0) begin
                    if (beat == LAST_BEAT) begin
                        beat  <= '0;
                        raw_x <= sat_inc(raw_x);
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end else if (href_fall) begin
                    // A partial pixel left at line end is simply dropped.
                    beat  <= '0;
                    raw_x <= '0;
                    raw_y <= sat_inc(raw_y);
                end
                if (hit) begin
                    DataValid  <= 1'b1;
                    DataPixel  <= pix_next;
                    Xaddr      <= raw_x - cx0;
                    Yaddr      <= raw_y - cy0;
                    FrameStart <= (pix_cnt == 24'd0);
                    pix_cnt    <= pix_cnt + 24'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dvp_capture_crop.sv
// Directed bench for dvp_capture_crop (RGB565, 8-bit bus, SKIP_FRAMES=2).
// Byte (line y, index i) carries y*32+i so every pixel value is unique.
module tb_dvp_capture_crop;
    localparam int DATA_W = 8, BEATS = 2, ADDR_W = 12, SKIP_FRAMES = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [ADDR_W-1:0] crop_x0 = '0, crop_y0 = '0, crop_w = '0, crop_h = '0;
    logic [3:0] decim = '0;
    logic image_state, data_valid, frame_start, frame_done;
    logic [DATA_W*BEATS-1:0] data_pixel;
    logic [ADDR_W-1:0] xaddr, yaddr;
    logic [23:0] frame_pix_cnt;

    dvp_capture_crop_if #(.DATA_W(DATA_W)) cam ();

    dvp_capture_crop #(
        .DATA_W(DATA_W), .BEATS(BEATS), .ADDR_W(ADDR_W), .SKIP_FRAMES(SKIP_FRAMES)
    ) dut (
        .PCLK(clk), .Rst_n(rst_n), .cam(cam),
        .crop_x0(crop_x0), .crop_y0(crop_y0), .crop_w(crop_w), .crop_h(crop_h),
        .decim(decim), .ImageState(image_state), .DataValid(data_valid),
        .DataPixel(data_pixel), .Xaddr(xaddr), .Yaddr(yaddr),
        .FrameStart(frame_start), .FrameDone(frame_done),
        .frame_pix_cnt(frame_pix_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int pix; } exp_t;
    typedef struct {
        int x0; int y0; int w; int h; int nb; int nl;
        int strobes; int done; int cnt;
    } vec_t;

    exp_t q[$];
    vec_t vecs[6];
    int total = 0, bad = 0;
    int n_strobe = 0, n_start = 0, n_done = 0;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] bval(input int y, input int i);
        return 8'(y * 32 + i);
    endfunction

    task automatic vsync_pulse();
        cam.Vsync = 1'b1;
        step(3);
        cam.Vsync = 1'b0;
        step(3);
    endtask

    task automatic send_line(input int y, input int nb);
        cam.Href = 1'b1;
        for (int i = 0; i < nb; i++) begin
            cam.Data = bval(y, i);
            step();
        end
        cam.Href = 1'b0;
        cam.Data = '0;
        step(4);
    endtask

    // Model: raster-order strobes of the window clipped to the real frame.
    task automatic expect_frame(input int nb, input int nl, input int x0,
                                input int y0, input int w, input int h);
        exp_t e;
        for (int y = 0; y < nl; y++)
            for (int x = 0; x < nb / BEATS; x++)
                if (x >= x0 && x < x0 + w && y >= y0 && y < y0 + h) begin
                    e.x = x - x0;
                    e.y = y - y0;
                    e.pix = int'({bval(y, 2 * x), bval(y, 2 * x + 1)});
                    q.push_back(e);
                end
    endtask

    task automatic set_crop(input int x0, input int y0, input int w, input int h);
        crop_x0 = ADDR_W'(x0);
        crop_y0 = ADDR_W'(y0);
        crop_w  = ADDR_W'(w);
        crop_h  = ADDR_W'(h);
    endtask

    task automatic mon();
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_valid) begin
                n_strobe++;
                chk("strobe_expected", int'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("xaddr", int'(xaddr), e.x);
                    chk("yaddr", int'(yaddr), e.y);
                    chk("pixel", int'(data_pixel), e.pix);
                end
            end
            if (frame_start) begin
                n_start++;
                chk("start_with_valid", int'(data_valid), 1);
            end
            if (frame_done) n_done++;
        end
    endtask

    initial begin
        int s0, st0, d0;
        vecs[0] = '{0, 0, 8, 4, 16, 4, 32, 1, 32};
        vecs[1] = '{2, 1, 3, 2, 16, 4, 6, 1, 6};
        vecs[2] = '{0, 0, 20, 4, 16, 4, 32, 1, 32};
        vecs[3] = '{0, 0, 0, 4, 16, 4, 0, 0, 32};
        vecs[4] = '{0, 0, 8, 4, 15, 2, 14, 1, 14};
        vecs[5] = '{6, 3, 5, 5, 16, 4, 2, 1, 2};

        fork
            mon();
        join_none

        cam.Vsync = 1'b0;
        cam.Href  = 1'b0;
        cam.Data  = '0;
        step(3);
        chk("rst_image_state", int'(image_state), 1);
        chk("rst_valid", int'(data_valid), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_start", int'(frame_start), 0);
        chk("rst_pix_cnt", int'(frame_pix_cnt), 0);
        chk("rst_pixel", int'(data_pixel), 0);
        rst_n = 1'b1;
        step(2);

        // Start-up skip: two discarded frames, ImageState drops at boundary 2.
        set_crop(0, 0, 8, 4);
        vsync_pulse();
        for (int y = 0; y < 4; y++) send_line(y, 16);
        chk("skip1_image_state", int'(image_state), 1);
        cam.Vsync = 1'b1;
        step();
        chk("skip2_state_edge1", int'(image_state), 1);
        step();
        chk("skip2_state_edge2", int'(image_state), 0);
        step();
        cam.Vsync = 1'b0;
        step(3);
        for (int y = 0; y < 4; y++) send_line(y, 16);
        chk("skip_strobes", n_strobe, 0);

        // Table: one frame per record, crop inputs scrambled after line 0.
        for (int r = 0; r < 6; r++) begin
            s0 = n_strobe; st0 = n_start; d0 = n_done;
            set_crop(vecs[r].x0, vecs[r].y0, vecs[r].w, vecs[r].h);
            expect_frame(vecs[r].nb, vecs[r].nl, vecs[r].x0, vecs[r].y0,
                         vecs[r].w, vecs[r].h);
            vsync_pulse();
            send_line(0, vecs[r].nb);
            set_crop(1, 0, 0, 0);
            for (int y = 1; y < vecs[r].nl; y++) send_line(y, vecs[r].nb);
            vsync_pulse();
            step(2);
            chk($sformatf("v%0d_strobes", r), n_strobe - s0, vecs[r].strobes);
            chk($sformatf("v%0d_starts", r), n_start - st0, int'(vecs[r].strobes > 0));
            chk($sformatf("v%0d_done", r), n_done - d0, vecs[r].done);
            chk($sformatf("v%0d_pix_cnt", r), int'(frame_pix_cnt), vecs[r].cnt);
            chk($sformatf("v%0d_queue_left", r), q.size(), 0);
        end

        // Decimation: decim=2 keeps frames 1 and 4 of six.
        set_crop(0, 0, 8, 4);
        decim = 4'd2;
        d0 = n_done;
        for (int f = 0; f < 6; f++) begin
            st0 = n_start;
            if (f % 3 == 0) expect_frame(16, 1, 0, 0, 8, 4);
            vsync_pulse();
            send_line(0, 16);
            chk($sformatf("decim_f%0d_start", f + 1), n_start - st0, int'(f % 3 == 0));
        end
        vsync_pulse();
        chk("decim_done", n_done - d0, 2);
        chk("decim_pix_cnt", int'(frame_pix_cnt), 8);
        chk("decim_queue_left", q.size(), 0);

        // Latency: last beat launched at edge N, strobe registered at N+2.
        decim = 4'd0;
        vsync_pulse();
        s0 = n_strobe; d0 = n_done;
        vsync_pulse();
        expect_frame(2, 1, 0, 0, 8, 4);
        cam.Href = 1'b1;
        cam.Data = bval(0, 0);
        step();
        cam.Data = bval(0, 1);
        step();
        cam.Href = 1'b0;
        chk("lat_early", int'(data_valid), 0);
        step();
        chk("lat_hit", int'(data_valid), 1);
        chk("lat_pixel", int'(data_pixel), int'({bval(0, 0), bval(0, 1)}));
        step();
        chk("lat_one_cycle", int'(data_valid), 0);
        step(4);

        // Vsync rising mid-pixel: boundary wins, half pixel dropped.
        cam.Href = 1'b1;
        cam.Data = 8'hA5;
        step();
        cam.Vsync = 1'b1;
        cam.Data = 8'h5A;
        step();
        cam.Href = 1'b0;
        step(3);
        cam.Vsync = 1'b0;
        step(4);
        chk("vs_href_strobes", n_strobe - s0, 1);
        chk("vs_href_done", n_done - d0, 1);
        chk("vs_href_pix_cnt", int'(frame_pix_cnt), 1);

        // Asynchronous reset mid-line.
        vsync_pulse();
        expect_frame(4, 1, 0, 0, 8, 4);
        cam.Href = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cam.Data = bval(0, i);
            step();
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(data_valid), 0);
        chk("mid_rst_xaddr", int'(xaddr), 0);
        chk("mid_rst_pix_cnt", int'(frame_pix_cnt), 0);
        chk("mid_rst_image_state", int'(image_state), 1);
        step(3);
        rst_n = 1'b1;
        for (int i = 5; i < 16; i++) begin
            cam.Data = bval(0, i);
            step();
        end
        cam.Href = 1'b0;
        step(4);
        vsync_pulse();
        send_line(0, 16);
        chk("post_rst_skip1", int'(image_state), 1);
        vsync_pulse();
        chk("post_rst_skip2", int'(image_state), 0);
        chk("post_rst_queue_left", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dvp_capture_crop.md
# dvp_capture_crop

Parametrised DVP camera capture stage with runtime crop window, start-up frame skip and frame decimation. Sits between the camera pins (PCLK domain) and the DDR write FIFO: it assembles multi-beat pixels from the byte bus and emits one-cycle-valid pixels with window-relative coordinates. It also provides a FIFO-clear status and per-frame pulses. Supports 1/2/3-beat pixels (RAW8/Y8, RGB565, RGB888).

## Interface
- DATA_W, 8, DVP data bus width
- BEATS, 2, bus beats per pixel (1, 2 or 3); first beat lands in MSBs
- ADDR_W, 12, coordinate counter width
- SKIP_FRAMES, 10, frames discarded after reset (camera settling), 0..255
- PCLK  in  1  camera pixel clock, sole clock
- Rst_n  in  1  asynchronous active-low reset
- Vsync  in  1  camera vsync, high = vertical blanking
- Href  in  1  camera line valid
- Data  in  DATA_W  camera data
- crop_x0, crop_y0  in  ADDR_W  window origin, pixels/lines
- crop_w, crop_h  in  ADDR_W  window size; 0 = capture nothing
- decim  in  4  keep one frame out of decim+1
- ImageState  out  1  high until SKIP_FRAMES frames elapsed (drives FIFO clear)
- DataValid  out  1  one-cycle pixel strobe
- DataPixel  out  DATA_W*BEATS  assembled pixel
- Xaddr, Yaddr  out  ADDR_W  window-relative coordinates, start 0
- FrameStart  out  1  one-cycle pulse, start of a captured frame
- FrameDone  out  1  one-cycle pulse, end of a captured frame
- frame_pix_cnt  out  24  valid pixels emitted in last captured frame

## Operation
- Vsync, Href, Data registered once (stage 1); all decisions use registered copies.
- Vsync rising edge (registered) = frame boundary: skip counter increments (saturates at SKIP_FRAMES), decimation counter advances modulo decim+1, crop_* and decim latched, line/pixel counters cleared.
- ImageState = 1 while skip count < SKIP_FRAMES; drops to 0 on the boundary that reaches it. SKIP_FRAMES=0: ImageState low after reset.
- Frame "active" when ImageState=0 and decimation counter = 0 at the boundary. Non-active frames produce no DataValid, FrameStart or FrameDone.
- Line: beat counter 0..BEATS-1 advances each Href-high cycle; on last beat pixel completes and raw X increments. Href falling edge: raw Y increments, beat counter and raw X clear; partial pixel discarded.
- DataValid when pixel completes in an active frame and crop_x0 ≤ rawX < crop_x0+crop_w and crop_y0 ≤ rawY < crop_y0+crop_h (sums in ADDR_W+1 bits). Xaddr = rawX−crop_x0, Yaddr = rawY−crop_y0.
- Windows extending past the real line/frame are truncated, not padded. Raw counters saturate at 2^ADDR_W−1.
- FrameStart: first DataValid of an active frame, same cycle. FrameDone: boundary closing an active frame that emitted ≥1 pixel; frame_pix_cnt updates in that cycle.
- Runtime input changes mid-frame have no effect until the next boundary.

## Timing
- Reset: ImageState=1 (0 if SKIP_FRAMES=0); all other outputs 0; counters 0; latched crop = 0 (nothing captured before first boundary).
- Latency: last beat of a pixel at input edge N → DataValid/DataPixel/Xaddr/Yaddr registered at edge N+2, high exactly one cycle.
- Back-to-back pixels: DataValid at most once per BEATS cycles; BEATS=1 allows continuous strobe.
- FrameDone/ImageState change 2 edges after raw Vsync rises.
- Vsync rising while Href high: boundary wins, in-progress pixel dropped, no DataValid.
- Rst_n assertion mid-frame: outputs clear immediately; capture resumes only after the next Vsync boundary.

## Test plan
- SKIP_FRAMES=2, decim=0, 8×4 RGB565 frames, full window: frames 1–2 give no DataValid and ImageState=1; frame 3 gives 32 strobes, pixel = {byte0,byte1}, FrameDone with frame_pix_cnt=32.
- Crop x0=2,y0=1,w=3,h=2 on 8×4 frame: exactly 6 strobes, Xaddr 0..2, Yaddr 0..1, first pixel = raw (2,1).
- decim=2 over 6 post-skip frames: FrameStart/FrameDone only on frames 1 and 4.
- Odd byte count line (15 bytes, BEATS=2): 7 pixels, trailing byte dropped, next line aligned on beat 0.
- Window w=20 on 8-pixel lines: 8 strobes per line, no wrap; crop_w=0: zero strobes, no FrameDone.
- Rst_n low for 3 cycles mid-line: all outputs 0 next cycle, ImageState=1, skip restarts from zero.
